hog_custom_fifo: RTL and testbench
==================================

# hog_custom_fifo

Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides, used as the streaming buffer between pixel/cell pipeline stages of the HOG datapath. It supports arbitrary (non-power-of-two) depths. Besides full/empty handshaking, it raises `border_flag` on the entry that closes each `FIFO_DEPTH`-long group. Downstream windowing logic uses that flag to detect row/block borders.

## Interface
- `DATA_WIDTH`, default 8: width of each stored word.
- `FIFO_DEPTH`, default 9: number of storage entries, ≥ 2, any integer (not restricted to powers of two).

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset, asynchronous, active-low (asserted when 0).
- `w_data`  in  DATA_WIDTH: write data.
- `w_valid`  in  1: write request.
- `w_ready`  out  1: FIFO can accept a word (`!fifo_full`).
- `r_data`  out  DATA_WIDTH: head-of-FIFO word, valid whenever `r_valid`=1.
- `r_valid`  out  1: FIFO non-empty.
- `r_ready`  in  1: consumer accepts head word.
- `fifo_full`  out  1: occupancy == `FIFO_DEPTH`.
- `border_flag`  out  1: head word is the last of a `FIFO_DEPTH` group (see Operation).

## Operation
- Write transfer: `w_valid && w_ready` at a rising edge. Store `w_data` at `wr_ptr` and advance `wr_ptr`.
- Read transfer: `r_valid && r_ready` at a rising edge. Advance `rd_ptr`.
- Pointer range: both pointers run 0..`FIFO_DEPTH`-1 and wrap explicitly to 0 after `FIFO_DEPTH`-1. No modulo-2^n arithmetic.
- Occupancy counter: `count`, width $clog2(`FIFO_DEPTH`+1).
  - +1 on write only.
  - −1 on read only.
  - Unchanged on simultaneous write and read.
- Derived flags:
  - `r_valid` = (`count` != 0).
  - `fifo_full` = (`count` == `FIFO_DEPTH`).
  - `w_ready` = !`fifo_full`.
- Full-state writes: when full, a write is refused even if a read occurs in the same cycle. There is no full-state pass-through.
- Empty-state reads: when empty, a read is ignored (`r_valid`=0). `r_data` is don't-care and must not be relied on.
- Read data path: `r_data` = `mem[rd_ptr]`, combinational from the storage array (first-word fall-through).
- `border_flag` = `r_valid && (rd_ptr == FIFO_DEPTH-1)`, combinational. It is high for the head word stored in the last slot. That is every `FIFO_DEPTH`-th word since reset, counting from 1.
- Storage contents are not reset. Pointers, count and all flags are reset.

## Timing
- Reset (`rst`=0) values:
  - `wr_ptr`=0, `rd_ptr`=0, `count`=0.
  - `r_valid`=0, `fifo_full`=0, `w_ready`=1, `border_flag`=0.
- Reset is asynchronous: outputs change on the reset edge without waiting for a clock. Reset asserted mid-operation discards all contents immediately.
- Write-to-read latency: 1 cycle. A word written at edge N is on `r_data` with `r_valid`=1 right after edge N.
- Throughput: 1 word/cycle sustained with `w_valid`=`r_ready`=1. Occupancy stays at 1 in steady state.
- `fifo_full`/`w_ready` update on the edge that completes the `FIFO_DEPTH`-th outstanding write. They clear on the edge of the first subsequent read.
- Wrap: simultaneous write at `wr_ptr`=`FIFO_DEPTH`-1 and read at `rd_ptr`=`FIFO_DEPTH`-1 wraps both pointers to 0 in the same edge.

## Structure
- Single module, no sub-modules.
- Storage is a register array of `FIFO_DEPTH` × `DATA_WIDTH`. It must map to distributed RAM or flops; asynchronous read is required.
- No shared-package contents needed. The pointer width $clog2(`FIFO_DEPTH`) and count width are local parameters.

## Test plan
- Reset: hold `rst`=0 for 2 clocks → `r_valid`=0, `w_ready`=1, `fifo_full`=0, `border_flag`=0. Releasing reset causes no spurious transfers.
- Streaming: `w_valid`=`r_ready`=1 with random data, `FIFO_DEPTH`=9 → each word appears on `r_data` one cycle after its write. Order is preserved and there are no drops or duplicates over 100 words.
- Backpressure: after steady streaming, `r_ready`=0 for 5 cycles → occupancy grows 1→6 and `w_ready` stays 1. Then `r_ready`=1, `w_valid`=0 for 5 cycles → the 6 words drain in order and `r_valid` drops when empty.
- Full: `r_ready`=0 and 12 write attempts → `fifo_full`=1, `w_ready`=0 after the 9th; writes 10–12 are discarded. Draining then returns words 1–9 exactly.
- Border: write 20 words 0..19 with continuous reads → `border_flag`=1 exactly while words 8 and 17 are at the head.
- Simultaneous read+write while full → the read succeeds, the write is refused, and `count` goes 9→8.

Source files
------------

// File: rtl/hog_custom_fifo_pkg.sv
// Shared definitions for the HOG streaming FIFO: default geometry and the
// per-cycle transfer classification used to update occupancy.
package hog_custom_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 9;

  // Encoding is {write_transfer, read_transfer} so it can be cast directly.
  typedef enum logic [1:0] {
    XFER_IDLE = 2'b00,
    XFER_RD   = 2'b01,
    XFER_WR   = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

endpackage

// File: rtl/hog_custom_fifo.sv
// First-word-fall-through FIFO for arbitrary depth, with explicit pointer wrap
// and a border flag marking the head word held in the last storage slot.
module hog_custom_fifo
  import hog_custom_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_valid,
  output logic                  w_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic                  fifo_full,
  output logic                  border_flag
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic  wr_en;
  logic  rd_en;
  xfer_e xfer;

  // Status flags and handshakes derive purely from occupancy; a full FIFO
  // refuses writes even when a read frees a slot in the same cycle.
  always_comb begin
    r_valid     = (count_q != '0);
    fifo_full   = (count_q == FULL_CNT);
    w_ready     = !fifo_full;
    wr_en       = w_valid && w_ready;
    rd_en       = r_valid && r_ready;
    xfer        = xfer_e'({wr_en, rd_en});
    r_data      = mem_q[rd_ptr_q];
    border_flag = r_valid && (rd_ptr_q == LAST_PTR);
  end

  // Next-state for pointers (explicit wrap, no power-of-two assumption) and count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
    end

    unique case (xfer)
      XFER_WR:   count_d = count_q + CNT_ONE;
      XFER_RD:   count_d = count_q - CNT_ONE;
      default:   count_d = count_q;
    endcase
  end

  // Control state; reset discards contents immediately by clearing occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array: unreset, written on accepted writes, read asynchronously.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= w_data;
    end
  end

endmodule

// File: tb/tb_hog_custom_fifo.sv
// Scoreboard bench for hog_custom_fifo: stimulus pushes expected words when a
// write is accepted by the reference occupancy, a negedge monitor checks flags,
// head data and border marking, and pops on each read transfer.
module tb_hog_custom_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 9;

  typedef struct {
    logic [DW-1:0] data;
    logic          border;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] w_data = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_ready = 1'b0;
  logic          fifo_full;
  logic          border_flag;

  hog_custom_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .w_data      (w_data),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .fifo_full   (fifo_full),
    .border_flag (border_flag)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  int   wr_idx = 0;
  int   pops = 0;
  int   border_hits = 0;
  int   border_sum = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    bit   full_m;
    if (!rst) begin
      sb.delete();
      wr_idx = 0;
      chk("rst_r_valid", 32'(r_valid), 32'd0);
      chk("rst_w_ready", 32'(w_ready), 32'd1);
      chk("rst_fifo_full", 32'(fifo_full), 32'd0);
      chk("rst_border", 32'(border_flag), 32'd0);
    end else begin
      full_m = (sb.size() == DEPTH);
      chk("fifo_full", 32'(fifo_full), 32'(full_m));
      chk("w_ready", 32'(w_ready), 32'(!full_m));
      chk("r_valid", 32'(r_valid), 32'(sb.size() != 0));
      if (r_valid && sb.size() != 0) begin
        chk("r_data", 32'(r_data), 32'(sb[0].data));
        chk("border_flag", 32'(border_flag), 32'(sb[0].border));
      end
      if (r_valid && r_ready) begin
        if (sb.size() == 0) begin
          chk("read_from_empty_model", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          pops++;
          if (border_flag) begin
            border_hits++;
            border_sum += int'(r_data);
          end
        end
      end
      if (w_valid && !full_m) begin
        e.data   = w_data;
        e.border = ((wr_idx % DEPTH) == DEPTH - 1);
        sb.push_back(e);
        wr_idx++;
      end
    end
  end

  task automatic cyc(input logic wv, input logic [DW-1:0] wd, input logic rr);
    w_valid = wv;
    w_data  = wd;
    r_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    w_valid = 1'b0;
    r_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("por_r_valid", 32'(r_valid), 32'd0);
    chk("por_w_ready", 32'(w_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("no_spurious_after_release", 32'(r_valid), 32'd0);

    // Streaming 100 words with continuous write and read.
    for (int i = 0; i < 100; i++) cyc(1'b1, DW'($urandom), 1'b1);
    chk("stream_occupancy_one", 32'(r_valid), 32'd1);

    // Backpressure: occupancy grows from 1 to 6.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'hA0 + i), 1'b0);
    chk("bp_w_ready", 32'(w_ready), 32'd1);
    pops = 0;
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1);
    chk("bp_drain_count", 32'(pops), 32'd6);
    chk("bp_empty_after_drain", 32'(r_valid), 32'd0);

    // Full: 12 write attempts without reads, words 1..12.
    for (int i = 1; i <= 12; i++) cyc(1'b1, DW'(i), 1'b0);
    chk("full_after_12", 32'(fifo_full), 32'd1);
    chk("full_w_ready", 32'(w_ready), 32'd0);
    chk("full_head", 32'(r_data), 32'd1);
    pops = 0;
    cyc(1'b1, DW'(99), 1'b1);
    chk("full_rw_not_full", 32'(fifo_full), 32'd0);
    chk("full_rw_head", 32'(r_data), 32'd2);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1);
    chk("full_drain_count", 32'(pops), 32'd9);
    chk("full_empty", 32'(r_valid), 32'd0);

    // Border: from reset, words 0..19 streamed; flag on words 8 and 17.
    do_reset();
    border_hits = 0;
    border_sum  = 0;
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(i), 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("border_hits", 32'(border_hits), 32'd2);
    chk("border_sum", 32'(border_sum), 32'd25);

    // Wrap under simultaneous read and write, then asynchronous mid-cycle reset.
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(8'h50 + i), 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, DW'(8'h60 + i), 1'b1);
    chk("wrap_valid", 32'(r_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_r_valid", 32'(r_valid), 32'd0);
    chk("async_rst_w_ready", 32'(w_ready), 32'd1);
    chk("async_rst_border", 32'(border_flag), 32'd0);
    w_valid = 1'b0;
    r_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc(1'b0, '0, 1'b1);
    chk("post_rst_empty", 32'(r_valid), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
